// File: rtl/pkg_dtypes.sv
// Shared datatypes for the execution-unit / interconnect boundary.
// The type_icon_txq_entry struct is the storage element of the transmit queue.
package pkg_dtypes;

    typedef struct packed {
        logic [3:0] eu_idx;
        logic [3:0] reg_idx;
    } type_exec_unit_addr;

    typedef logic [31:0] type_exec_unit_data;

    typedef struct packed {
        type_exec_unit_data opd_data;
        type_exec_unit_addr opd_addr;
        logic               opd_opx;
        logic               opd_valid;
    } type_alpu_channel_tx;

    typedef struct packed {
        type_exec_unit_addr addr;
        type_exec_unit_data data;
        logic               valid;
    } type_icon_tx_channel;

    typedef struct packed {
        logic                opx;
        type_icon_tx_channel tx;
    } type_icon_channel;

    typedef struct packed {
        logic ready;
    } type_icon_rx_channel;

    typedef struct packed {
        logic               opx;
        type_exec_unit_addr addr;
        type_exec_unit_data data;
    } type_icon_txq_entry;

endpackage

// File: rtl/eu_icon_txq.sv
// Transmit queue from an execution unit's ALPU result port to the interconnect.
// Circular FIFO; the head entry is presented combinationally from storage.
module eu_icon_txq
    import pkg_dtypes::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  type_alpu_channel_tx i_alpu_tx,
    output logic                o_alpu_ready,
    output type_icon_channel    o_icon,
    input  type_icon_rx_channel i_icon_rx,
    output logic [PTR_W:0]      o_count
);

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    type_icon_txq_entry mem_q [DEPTH];
    type_icon_txq_entry head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop, valid;

    // Ready decodes registered occupancy only: a pop at full never frees a slot in the same cycle.
    always_comb begin
        o_alpu_ready = (count_q != FULL_CNT);
        valid        = (count_q != '0);
        push         = i_alpu_tx.opd_valid & o_alpu_ready;
        pop          = valid & i_icon_rx.ready;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset; occupancy alone qualifies its contents.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{opx:  i_alpu_tx.opd_opx,
                                 addr: i_alpu_tx.opd_addr,
                                 data: i_alpu_tx.opd_data};
        end
    end

    always_comb begin
        head           = mem_q[rd_ptr_q];
        o_icon.opx     = head.opx;
        o_icon.tx.addr = head.addr;
        o_icon.tx.data = head.data;
        o_icon.tx.valid = valid;
        o_count        = count_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rstn) begin
            assert (count_q <= FULL_CNT);
            assert (!(pop && (count_q == '0)));
        end
    end

endmodule
